// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and one FIFO write port.
// Latency: n/a (wiring only).
// Backpressure: req_ready per producer, full from the FIFO.
//
// slave  : arbiter view (takes requests and full, drives ready / FIFO write / status)
// master : producer + FIFO view (the opposite directions)
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      full;
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;

    modport slave (
        input  req_valid, req_last, req_data, full,
        output req_ready, wr_en, wr_data, grant_id, busy
    );

    modport master (
        output req_valid, req_last, req_data, full,
        input  req_ready, wr_en, wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Latency: one arbitration bubble after IDLE, then one beat per cycle (wr_en combinational).
// Backpressure: full=1 deasserts the owner's ready and stalls the burst; grant is held.
//
// Ports: wr_clk (write clock), wr_rst (async active-low reset),
//        bus.slave: req_valid/req_last/req_data in, req_ready out, full in,
//        wr_en/wr_data out to the FIFO, grant_id/busy status out.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt, w_owner_inc;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_pick;
    logic                 w_pick_vld;

    logic               w_own_valid, w_own_last;
    logic [DATA_W-1:0]  w_own_data;
    logic               w_xfer, w_release;
    logic [NUM_REQ-1:0] w_ready;

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit of the
    // rotated vector is the distance from rr_ptr to the winner.
    always_comb begin
        w_dbl      = {bus.req_valid, bus.req_valid} >> r_rr_ptr;
        w_rot      = w_dbl[NUM_REQ-1:0];
        w_off      = '0;
        w_pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off      = IDX_W'(k);
                w_pick_vld = 1'b1;
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            w_pick = IDX_W'(w_sum - (IDX_W + 1)'(NUM_REQ));
        end else begin
            w_pick = w_sum[IDX_W-1:0];
        end
    end

    // Owner's lane; non-owner data/last never reach the datapath.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_valid = bus.req_valid[i];
                w_own_last  = bus.req_last[i];
                w_own_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        w_xfer         = 1'b0;
        w_release      = 1'b0;
        w_ready        = '0;

        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt    = S_GRANT;
                    w_owner_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    w_ready[i] = (r_owner == IDX_W'(i)) && !bus.full;
                end
                w_xfer = w_own_valid && !bus.full;
                // Last beat, burst cap and owner going idle all collapse into
                // one release so rr_ptr advances exactly once.
                w_release = (w_xfer && (w_own_last || (r_beat_cnt == CNT_W'(MAX_BURST - 1))))
                            || !w_own_valid;
                if (w_xfer && (r_beat_cnt != CNT_W'(MAX_BURST))) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
                if (w_release) begin
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = w_owner_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_en     = w_xfer;
    assign bus.wr_data   = w_xfer ? w_own_data : '0;
    assign bus.grant_id  = r_owner;
    assign bus.busy      = (r_state == S_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected (grant_id, data) pairs are queued
// as producer streams are loaded and popped when wr_en is observed.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b0;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] dat;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    bit   wr_trace[$];
    bit   busy_trace[$];
    logic [1:0] gid_trace[$];
    logic [NR-1:0] rdy_trace[$];

    int         p_left[NR];
    int         p_sent[NR];
    int         p_last[NR];
    logic [7:0] p_base[NR];
    bit         acc[NR];
    int         n_xfer;

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = (p_left[i] > 0);
            bus.req_data[i*DW +: DW]  = p_base[i] + 8'(p_sent[i]);
            bus.req_last[i]           = (p_last[i] != 0) && (((p_sent[i] + 1) % p_last[i]) == 0);
        end
    endtask

    task automatic push_stream(input int id, input int beats);
        exp_t e;
        for (int k = 0; k < beats; k++) begin
            e.id  = 2'(id);
            e.dat = p_base[id] + 8'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_traces();
        wr_trace.delete();
        busy_trace.delete();
        gid_trace.delete();
        rdy_trace.delete();
        n_xfer = 0;
    endtask

    // One cycle: sample at negedge, scoreboard any write, advance producers after the edge.
    task automatic step();
        exp_t e;
        @(negedge wr_clk);
        wr_trace.push_back(bus.wr_en);
        busy_trace.push_back(bus.busy);
        gid_trace.push_back(bus.grant_id);
        rdy_trace.push_back(bus.req_ready);
        n_cmp++;
        if (bus.wr_en && bus.full) begin
            n_err++;
            $display("FAIL wr_en_while_full: wr_en=%b full=%b required wr_en=0", bus.wr_en, bus.full);
        end
        n_cmp++;
        if (!$onehot0(bus.req_ready)) begin
            n_err++;
            $display("FAIL ready_onehot: req_ready=%b required one-hot or zero", bus.req_ready);
        end
        if (bus.wr_en) begin
            n_xfer++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: id=%0d data=%h required no write", bus.grant_id, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.grant_id !== e.id || bus.wr_data !== e.dat) begin
                    n_err++;
                    $display("FAIL write_data: got id=%0d data=%h required id=%0d data=%h",
                             bus.grant_id, bus.wr_data, e.id, e.dat);
                end
            end
        end
        for (int i = 0; i < NR; i++) acc[i] = bus.req_ready[i] && bus.req_valid[i];
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                p_sent[i]++;
                p_left[i]--;
            end
        end
        drive();
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            step();
            b--;
        end
        repeat (2) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d writes outstanding required 0", name, exp_q.size());
        end
    endtask

    task automatic do_reset();
        wr_rst   = 1'b0;
        bus.full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            p_left[i] = 0; p_sent[i] = 0; p_last[i] = 0; p_base[i] = '0;
        end
        drive();
        exp_q.delete();
        repeat (2) @(posedge wr_clk);
        #1;
        wr_rst = 1'b1;
        clear_traces();
    endtask

    task automatic test_reset();
        wr_rst        = 1'b0;
        bus.full      = 1'b0;
        bus.req_valid = '1;
        bus.req_last  = '0;
        bus.req_data  = 32'hDEADBEEF;
        repeat (4) begin
            @(negedge wr_clk);
            n_cmp++;
            if (bus.req_ready !== '0 || bus.wr_en !== 1'b0 || bus.grant_id !== 2'd0 ||
                bus.busy !== 1'b0 || bus.wr_data !== 8'h00) begin
                n_err++;
                $display("FAIL reset_outputs: ready=%b wr_en=%b gid=%0d busy=%b data=%h required all 0",
                         bus.req_ready, bus.wr_en, bus.grant_id, bus.busy, bus.wr_data);
            end
        end
    endtask

    task automatic test_single_burst();
        bit exp_w;
        do_reset();
        p_left[2] = 3; p_base[2] = 8'hA0; p_last[2] = 3;
        push_stream(2, 3);
        drive();
        repeat (6) step();
        for (int c = 0; c < 6; c++) begin
            exp_w = (c >= 1 && c <= 3);
            n_cmp++;
            if (wr_trace[c] !== exp_w || busy_trace[c] !== exp_w) begin
                n_err++;
                $display("FAIL single_cycle%0d: wr_en=%b busy=%b required %b", c, wr_trace[c], busy_trace[c], exp_w);
            end
            if (exp_w) begin
                n_cmp++;
                if (gid_trace[c] !== 2'd2) begin
                    n_err++;
                    $display("FAIL single_gid%0d: grant_id=%0d required 2", c, gid_trace[c]);
                end
            end
        end
        // rr_ptr now points at 3, so 3 must beat 0.
        p_left[0] = 1; p_base[0] = 8'h55; p_last[0] = 1;
        p_left[3] = 1; p_base[3] = 8'h66; p_last[3] = 1;
        push_stream(3, 1);
        push_stream(0, 1);
        drive();
        drain("single_rrptr", 20);
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit exp_w;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            p_left[i] = 2; p_base[i] = 8'(16 * i); p_last[i] = 1;
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                e.id = 2'(i); e.dat = 8'(16 * i + r);
                exp_q.push_back(e);
            end
        end
        drive();
        repeat (16) step();
        for (int c = 0; c < 16; c++) begin
            exp_w = (c % 2) == 1;
            n_cmp++;
            if (wr_trace[c] !== exp_w) begin
                n_err++;
                $display("FAIL rr_cycle%0d: wr_en=%b required %b", c, wr_trace[c], exp_w);
            end
        end
        drain("rr", 10);
    endtask

    task automatic test_max_burst();
        int runs[$];
        int len;
        do_reset();
        p_left[1] = 10; p_base[1] = 8'hB0; p_last[1] = 0;
        push_stream(1, 10);
        drive();
        repeat (16) step();
        len = 0;
        foreach (wr_trace[c]) begin
            if (wr_trace[c]) len++;
            else if (len != 0) begin
                runs.push_back(len);
                len = 0;
            end
        end
        if (len != 0) runs.push_back(len);
        n_cmp++;
        if (runs.size() != 3) begin
            n_err++;
            $display("FAIL maxburst_runs: %0d bursts required 3", runs.size());
        end else begin
            n_cmp++;
            if (runs[0] != 4 || runs[1] != 4 || runs[2] != 2) begin
                n_err++;
                $display("FAIL maxburst_len: bursts %0d,%0d,%0d required 4,4,2", runs[0], runs[1], runs[2]);
            end
        end
        drain("maxburst", 5);
    endtask

    task automatic test_full();
        int b;
        do_reset();
        p_left[0] = 4; p_base[0] = 8'hC0; p_last[0] = 4;
        push_stream(0, 4);
        drive();
        b = 20;
        while (n_xfer < 2 && b > 0) begin
            step();
            b--;
        end
        n_cmp++;
        if (n_xfer != 2) begin
            n_err++;
            $display("FAIL full_prefix: %0d beats required 2", n_xfer);
        end
        bus.full = 1'b1;
        repeat (5) begin
            step();
            n_cmp++;
            if (rdy_trace[$] !== 4'b0000 || wr_trace[$] !== 1'b0 || busy_trace[$] !== 1'b1 || gid_trace[$] !== 2'd0) begin
                n_err++;
                $display("FAIL full_stall: ready=%b wr_en=%b busy=%b gid=%0d required 0000 0 1 0",
                         rdy_trace[$], wr_trace[$], busy_trace[$], gid_trace[$]);
            end
        end
        bus.full = 1'b0;
        drain("full", 20);
        n_cmp++;
        if (n_xfer != 4) begin
            n_err++;
            $display("FAIL full_beats: %0d beats required 4", n_xfer);
        end
    endtask

    task automatic test_owner_drop();
        int b;
        exp_t e;
        do_reset();
        p_left[3] = 4; p_base[3] = 8'hD0; p_last[3] = 0;
        push_stream(3, 2);
        drive();
        b = 20;
        while (n_xfer < 1 && b > 0) begin step(); b--; end
        p_left[1] = 2; p_base[1] = 8'hE0; p_last[1] = 2;
        drive();
        while (n_xfer < 2 && b > 0) begin step(); b--; end
        n_cmp++;
        if (n_xfer != 2) begin
            n_err++;
            $display("FAIL drop_prefix: %0d beats required 2", n_xfer);
        end
        p_left[3] = 0;
        e.id = 2'd1; e.dat = 8'hE0;
        exp_q.push_back(e);
        drive();
        clear_traces();
        repeat (3) step();
        n_cmp++;
        if (busy_trace[0] !== 1'b1 || wr_trace[0] !== 1'b0) begin
            n_err++;
            $display("FAIL drop_c0: busy=%b wr_en=%b required 1 0", busy_trace[0], wr_trace[0]);
        end
        n_cmp++;
        if (busy_trace[1] !== 1'b0 || wr_trace[1] !== 1'b0) begin
            n_err++;
            $display("FAIL drop_c1: busy=%b wr_en=%b required 0 0", busy_trace[1], wr_trace[1]);
        end
        n_cmp++;
        if (busy_trace[2] !== 1'b1 || gid_trace[2] !== 2'd1 || wr_trace[2] !== 1'b1) begin
            n_err++;
            $display("FAIL drop_c2: busy=%b gid=%0d wr_en=%b required 1 1 1", busy_trace[2], gid_trace[2], wr_trace[2]);
        end
        // Mid-burst async reset, well away from any clock edge.
        #2;
        n_cmp++;
        if (bus.wr_en !== 1'b1 || bus.req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL prereset: wr_en=%b ready=%b required 1 0010", bus.wr_en, bus.req_ready);
        end
        wr_rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.wr_en !== 1'b0 || bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: wr_en=%b ready=%b busy=%b required 0 0000 0", bus.wr_en, bus.req_ready, bus.busy);
        end
        repeat (2) begin
            @(negedge wr_clk);
            n_cmp++;
            if (bus.wr_en !== 1'b0 || bus.req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold: wr_en=%b ready=%b required 0 0000", bus.wr_en, bus.req_ready);
            end
        end
        do_reset();
    endtask

    initial begin
        bus.full      = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_full();
        test_owner_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
